// File: rtl/cube_rot_seq.sv
// Cube face-rotation sequencer: walks a window of orientation words through
// read, ALU execute and write-back, skipping words with an invalid orientation.
module cube_rot_seq #(
    parameter int         AW          = 8,
    parameter int         DW          = 8,
    parameter logic [4:0] OP_ROT_BASE = 5'd8
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_axis,
    input  logic [1:0]    cmd_turns,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW-1:0] cmd_count,

    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,

    output logic [4:0]    alu_op,
    output logic [DW-1:0] alu_in0,
    input  logic [DW-1:0] alu_out,

    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EX,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] ONE = AW'(1);

    state_t        state_q;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] rem_q;
    logic [DW-1:0] opnd_q;
    logic [DW-1:0] wdata_q;
    logic          re_q;
    logic          we_q;
    logic          done_q;
    logic [4:0]    op_q;
    logic          err_q;
    logic [AW-1:0] err_cnt_q;

    logic [1:0]    turns_m1;
    logic [4:0]    op_d;
    logic          bad_word;
    logic [AW-1:0] err_cnt_d;

    // NOTE: always_comb assigns every output on every path so no latch is inferred.
    always_comb begin
        turns_m1  = cmd_turns - 2'd1;
        op_d      = OP_ROT_BASE + {3'b000, turns_m1} * 5'd3 + {3'b000, cmd_axis};
        bad_word  = (mem_rdata[2:1] == 2'b11);
        err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ONE;
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            opnd_q    <= '0;
            wdata_q   <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            op_q      <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        err_q     <= 1'b0;
                        err_cnt_q <= '0;
                        ptr_q     <= cmd_base;
                        rem_q     <= cmd_count;
                        if (cmd_turns == 2'd0 || cmd_count == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (cmd_axis == 2'd3) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            op_q    <= op_d;
                            re_q    <= 1'b1;
                            state_q <= S_RD;
                        end
                    end
                end

                S_RD: begin
                    re_q    <= 1'b0;
                    state_q <= S_EX;
                end

                S_EX: begin
                    opnd_q  <= mem_rdata;
                    wdata_q <= alu_out;
                    // Orientation codes 110/111 are not cube orientations: skip the write.
                    if (bad_word) begin
                        err_q     <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                        we_q      <= 1'b0;
                    end else begin
                        we_q      <= 1'b1;
                    end
                    state_q <= S_WR;
                end

                S_WR: begin
                    we_q  <= 1'b0;
                    ptr_q <= ptr_q + ONE;
                    rem_q <= rem_q - ONE;
                    if (rem_q == ONE) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        re_q    <= 1'b1;
                        state_q <= S_RD;
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    re_q    <= 1'b0;
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The ALU sees read data directly during EX so its result is ready for WR.
    assign alu_in0   = (state_q == S_EX) ? mem_rdata : opnd_q;
    assign alu_op    = op_q;

    assign mem_addr  = ptr_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_cube_rot_seq.sv
// Self-checking bench for cube_rot_seq: behavioural ALU and memory, a per-cycle
// expectation queue built from the command rules, and directed literal cases.
module tb_cube_rot_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_axis;
    logic [1:0] cmd_turns;
    logic [7:0] cmd_base;
    logic [7:0] cmd_count;
    logic [7:0] mem_addr;
    logic       mem_re;
    logic [7:0] mem_rdata;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [4:0] alu_op;
    logic [7:0] alu_in0;
    logic [7:0] alu_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem    [256];
    logic [7:0] shadow [256];

    typedef struct {
        bit         busy;
        bit         re;
        bit         we;
        bit         done;
        bit         err;
        bit         opchk;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] cnt;
        logic [7:0] in0;
        logic [4:0] op;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    bit         last_err = 0;
    logic [7:0] last_cnt = '0;

    cube_rot_seq #(.AW(8), .DW(8), .OP_ROT_BASE(5'd8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_axis  (cmd_axis),
        .cmd_turns (cmd_turns),
        .cmd_base  (cmd_base),
        .cmd_count (cmd_count),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .alu_op    (alu_op),
        .alu_in0   (alu_in0),
        .alu_out   (alu_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Quarter turn about one axis permutes four orientation codes and fixes two.
    function automatic logic [2:0] quarter(input int ax, input logic [2:0] o);
        logic [2:0] r;
        r = o;
        case (ax)
            0: case (o) 3'd0: r = 3'd2; 3'd2: r = 3'd5; 3'd5: r = 3'd4; 3'd4: r = 3'd0; default: r = o; endcase
            1: case (o) 3'd0: r = 3'd1; 3'd1: r = 3'd5; 3'd5: r = 3'd3; 3'd3: r = 3'd0; default: r = o; endcase
            default: case (o) 3'd1: r = 3'd2; 3'd2: r = 3'd3; 3'd3: r = 3'd4; 3'd4: r = 3'd1; default: r = o; endcase
        endcase
        return r;
    endfunction

    function automatic logic [7:0] alu_f(input logic [4:0] op, input logic [7:0] x);
        int         k;
        logic [2:0] o;
        if (op < 5'd8 || op > 5'd16 || x[2:0] > 3'd5) return x;
        k = int'(op) - 8;
        o = x[2:0];
        for (int t = 0; t <= k / 3; t++) o = quarter(k % 3, o);
        return {x[7:3], o};
    endfunction

    assign alu_out = alu_f(alu_op, alu_in0);

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [1:0] ax, input logic [1:0] tu,
                                input logic [7:0] base, input logic [7:0] cnt);
        exp_t       e;
        bit         ce;
        logic [7:0] cc;
        logic [7:0] a;
        logic [7:0] w;
        logic [4:0] op;
        bit         good;
        ce = 0;
        cc = '0;
        if (tu == 2'd0 || cnt == 8'd0 || ax == 2'd3) begin
            ce = (tu != 2'd0 && cnt != 8'd0);
        end else begin
            op = 5'(8 + 3 * (int'(tu) - 1) + int'(ax));
            for (int i = 0; i < int'(cnt); i++) begin
                a    = base + 8'(i);
                w    = shadow[a];
                good = (w[2:0] < 3'd6);
                e = '{default: 0};
                e.busy = 1; e.re = 1; e.addr = a; e.err = ce; e.cnt = cc;
                q.push_back(e);
                e.re = 0; e.opchk = 1; e.op = op; e.in0 = w;
                q.push_back(e);
                if (!good) begin
                    ce = 1;
                    if (cc != 8'hFF) cc++;
                end
                e.opchk = 0; e.we = good; e.wdata = alu_f(op, w); e.err = ce; e.cnt = cc;
                q.push_back(e);
            end
        end
        e = '{default: 0};
        e.busy = 1; e.done = 1; e.err = ce; e.cnt = cc;
        q.push_back(e);
        e.busy = 0; e.done = 0;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (rst_n && q.size() == 0 && cmd_valid)
            model_accept(cmd_axis, cmd_turns, cmd_base, cmd_count);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            last_err = 0;
            last_cnt = '0;
        end else if (q.size() == 0) begin
            check("idle_ready", cmd_ready, 1);
            check("idle_busy", busy, 0);
            check("idle_re", mem_re, 0);
            check("idle_we", mem_we, 0);
            check("idle_done", done, 0);
            check("idle_err", err, last_err);
            check("idle_err_cnt", err_cnt, last_cnt);
        end else begin
            cur = q.pop_front();
            check("busy", busy, cur.busy);
            check("ready", cmd_ready, !cur.busy);
            check("mem_re", mem_re, cur.re);
            check("mem_we", mem_we, cur.we);
            check("done", done, cur.done);
            check("err", err, cur.err);
            check("err_cnt", err_cnt, cur.cnt);
            if (cur.re || cur.we) check("mem_addr", mem_addr, cur.addr);
            if (cur.we) begin
                check("mem_wdata", mem_wdata, cur.wdata);
                shadow[cur.addr] = cur.wdata;
            end
            if (cur.opchk) begin
                check("alu_op", alu_op, cur.op);
                check("alu_in0", alu_in0, cur.in0);
            end
            last_err = cur.err;
            last_cnt = cur.cnt;
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] v);
        mem[a]    = v;
        shadow[a] = v;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) check("idle_timeout", q.size(), 0);
    endtask

    task automatic run_cmd(input logic [1:0] ax, input logic [1:0] tu,
                           input logic [7:0] base, input logic [7:0] cnt, output int lat);
        wait_idle();
        @(negedge clk);
        cmd_axis = ax; cmd_turns = tu; cmd_base = base; cmd_count = cnt; cmd_valid = 1;
        @(negedge clk);
        cmd_valid = 0;
        lat = 1;
        while (!done && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", done, 1);
    endtask

    initial begin
        int lat;
        int d1;
        int d2;
        rst_n = 0; cmd_valid = 0; cmd_axis = 0; cmd_turns = 0; cmd_base = 0; cmd_count = 0;
        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
        #2;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_re", mem_re, 0);
        check("rst_we", mem_we, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_in0", alu_in0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        preload(8'h10, 8'hA8);
        run_cmd(2'd0, 2'd1, 8'h10, 8'd1, lat);
        check("single_latency", lat, 4);
        check("single_alu_op", alu_op, 8);
        wait_idle();
        check("single_mem", mem[8'h10], 8'hAA);

        preload(8'hFE, 8'h51); preload(8'hFF, 8'h62); preload(8'h00, 8'h73); preload(8'h01, 8'h84);
        run_cmd(2'd2, 2'd2, 8'hFE, 8'd4, lat);
        check("wrap_latency", lat, 13);
        check("wrap_alu_op", alu_op, 13);
        wait_idle();
        check("wrap_mem_fe", mem[8'hFE], 8'h53);
        check("wrap_mem_ff", mem[8'hFF], 8'h64);
        check("wrap_mem_00", mem[8'h00], 8'h71);
        check("wrap_mem_01", mem[8'h01], 8'h82);

        preload(8'h20, 8'h07); preload(8'h21, 8'h01);
        run_cmd(2'd1, 2'd3, 8'h20, 8'd2, lat);
        check("bad_latency", lat, 7);
        check("bad_alu_op", alu_op, 15);
        check("bad_err", err, 1);
        check("bad_err_cnt", err_cnt, 1);
        wait_idle();
        check("bad_mem_20", mem[8'h20], 8'h07);
        check("bad_mem_21", mem[8'h21], 8'h00);

        run_cmd(2'd0, 2'd0, 8'h30, 8'd5, lat);
        check("turns0_latency", lat, 1);
        check("turns0_err", err, 0);
        run_cmd(2'd1, 2'd2, 8'h30, 8'd0, lat);
        check("count0_latency", lat, 1);
        run_cmd(2'd3, 2'd1, 8'h30, 8'd3, lat);
        check("axis3_latency", lat, 1);
        check("axis3_err", err, 1);

        // Reset arriving during the write-back cycle must kill the strobe at once.
        preload(8'h30, 8'h00);
        wait_idle();
        @(negedge clk);
        cmd_axis = 2'd0; cmd_turns = 2'd1; cmd_base = 8'h30; cmd_count = 8'd1; cmd_valid = 1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("wr_before_reset", mem_we, 1);
        rst_n = 0;
        #1;
        check("we_dropped_on_reset", mem_we, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        check("post_rst_err", err, 0);
        check("post_rst_err_cnt", err_cnt, 0);
        repeat (3) @(negedge clk);
        check("reset_mem_unchanged", mem[8'h30], 8'h00);

        preload(8'h50, 8'h00);
        wait_idle();
        @(negedge clk);
        cmd_axis = 2'd3; cmd_turns = 2'd1; cmd_base = 8'h40; cmd_count = 8'd2; cmd_valid = 1;
        d1 = 0; d2 = 0;
        for (int k = 1; k <= 20 && d2 == 0; k++) begin
            @(negedge clk);
            if (done) begin
                if (d1 == 0) d1 = k;
                else d2 = k;
            end
            if (k == 1) begin
                cmd_axis = 2'd0; cmd_base = 8'h50; cmd_count = 8'd1;
            end
            if (d2 != 0) cmd_valid = 0;
        end
        cmd_valid = 0;
        check("b2b_first_done", d1, 1);
        check("b2b_second_done", d2, 6);
        check("b2b_err_cleared", err, 0);
        wait_idle();
        check("b2b_mem", mem[8'h50], 8'h02);

        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            if ($urandom_range(0, 3) != 0) v[2:0] = 3'($urandom_range(0, 5));
            preload(8'(i), v);
        end
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_axis  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            cmd_turns = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            cmd_count = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 8));
            cmd_base  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
        end
        cmd_valid = 0;
        wait_idle();
        @(negedge clk);
        for (int i = 0; i < 256; i++) check("final_mem", mem[i], shadow[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
